ahb_output_arbiter: RTL and testbench
=====================================

# ahb_output_arbiter

Arbiter that shares one bus-matrix output stage between three input stages. It runs per output port, downstream of each input stage's address decoder. It chooses which requesting input stage drives the output's address phase, and holds that choice across bursts and locked sequences. It also registers the address-phase winner so the output data phase can be steered back to the correct input stage.

## Interface
Parameters:
- ARB_SCHEME, 1, arbitration scheme: 1 = round-robin, 0 = fixed priority (port 0 highest, port 2 lowest).

Ports:
- HCLK  in  1  AHB system clock; all state updates on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- req_in0, req_in1, req_in2  in  1 each  input stage i requests this output (decoder select, HTRANS ≠ IDLE, or a held transfer pending).
- trans_op  in  2  HTRANS currently presented on the output (from the granted input).
- lock_op  in  1  HMASTLOCK currently presented on the output.
- HREADYM  in  1  HREADY seen by the output port.
- addr_in_port  out  2  granted input index for the address phase (0..2).
- no_port  out  1  no input granted; output drives IDLE.
- active_op0, active_op1, active_op2  out  1 each  one-hot grant, equal to (addr_in_port == i) & ~no_port.
- data_in_port  out  2  input index owning the current data phase.
- data_valid  out  1  a data phase is in progress for data_in_port.

## Operation
- State machine with three states:
  - IDLE: no_port = 1.
  - GRANTED: owner set, not locked.
  - LOCKED: owner set, lock_op = 1.
- Re-arbitration is evaluated only when HREADYM = 1. With HREADYM = 0, all registers hold.
- Grant hold rules; when HREADYM = 1, the current owner is kept if:
  - trans_op = SEQ (2'b11) or BUSY (2'b01): mid-burst, no switch.
  - state is LOCKED: hold while lock_op = 1, even if the owner's request drops. Leave LOCKED when lock_op = 0 and trans_op = IDLE or NONSEQ.
- Otherwise the next owner is selected from requesters:
  - Round-robin: search from (last_owner + 1) mod 3 upward, wrapping from 2 to 0.
  - Fixed priority: lowest requesting index wins.
  - The current owner competes normally; if it is the only requester, it keeps the grant.
- No requests: go to IDLE, set no_port = 1, hold addr_in_port at its last value, and leave the round-robin pointer unchanged.
- last_owner updates only when a new grant is issued.
- Data phase: on HREADYM = 1, data_in_port <= addr_in_port and data_valid <= ~no_port & (trans_op is NONSEQ or SEQ).
- A request and an ownership release in the same cycle are resolved by the single arbitration evaluation above; there is no extra cycle.

## Timing
- Grant latency: a request sampled with HREADYM = 1 is reflected on addr_in_port, no_port and active_op* on the next rising edge. All outputs are registered.
- data_in_port and data_valid lag the address-phase grant by exactly one accepted transfer (one HREADYM = 1 edge).
- HREADYM held low for N cycles stretches every latency by N cycles.
- Reset values:
  - addr_in_port = 0, no_port = 1, active_op* = 0.
  - data_in_port = 0, data_valid = 0.
  - State = IDLE, last_owner = 2, so port 0 is favoured first under round-robin.
- HRESET asserted mid-burst or mid-lock returns everything to reset values immediately, without waiting for a clock edge. The first grant after release follows the normal one-cycle latency.

## Structure
- Shared package `ahb_matrix_pkg` holds:
  - HTRANS encodings: IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11.
  - Port index width (2).
  - The state encoding (IDLE, GRANTED, LOCKED).
- Sub-module `ahb_rr_pick`: combinational 3-way priority picker. Inputs: request vector and start index. Outputs: winner index and any_req. The same picker serves fixed priority with start index tied to 0.

## Test plan
- Reset, then req_in1 = 1 with HREADYM = 1 → one edge later addr_in_port = 1, active_op1 = 1, no_port = 0. One further accepted edge → data_in_port = 1, data_valid = 1.
- All three requesting continuously with NONSEQ-only transfers and round-robin → grant sequence 0, 1, 2, 0, 1, … with one change per HREADYM edge.
- Port 0 performs a 4-beat INCR4 (NONSEQ, SEQ, SEQ, SEQ) while req_in2 = 1 → port 0 holds for all 4 beats. Port 2 is granted on the edge after the last SEQ beat.
- Port 1 has lock_op = 1 for 3 transfers, with req_in1 dropping in between, while port 0 requests → port 1 is held throughout. Port 0 is granted only after lock_op = 0 with NONSEQ/IDLE.
- HREADYM = 0 for 5 cycles with port 2 newly requesting → no output changes during the stall. Grant moves on the first HREADYM = 1 edge.
- HRESET asserted during a SEQ beat → outputs return to reset values asynchronously. After release, with req_in0 = 1, port 0 is granted one edge later.

Source files
------------

// File: rtl/ahb_matrix_pkg.sv
// Shared definitions for the bus-matrix output stage: HTRANS codes, port index
// width and the output arbiter state encoding.
package ahb_matrix_pkg;

  localparam int PORT_W = 2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANTED = 2'b01;
  localparam logic [1:0] ST_LOCKED  = 2'b10;

  // Next port index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational 3-way picker: first requester found searching upward from start,
// wrapping 2 -> 0. Fixed priority is obtained by tying start to 0.
module ahb_rr_pick
  import ahb_matrix_pkg::*;
(
  input  logic [2:0]        req,
  input  logic [PORT_W-1:0] start,
  output logic [PORT_W-1:0] winner,
  output logic              any_req
);

  logic [3:0]        req_ext;
  logic [PORT_W-1:0] p1;
  logic [PORT_W-1:0] p2;

  assign req_ext = {1'b0, req};
  assign p1      = next_port(start);
  assign p2      = next_port(p1);
  assign any_req = |req;

  always_comb begin
    winner = start;
    if (req_ext[start])   winner = start;
    else if (req_ext[p1]) winner = p1;
    else if (req_ext[p2]) winner = p2;
  end

endmodule

// File: rtl/ahb_output_arbiter.sv
// Output-port arbiter of the bus matrix: picks which input stage owns the
// address phase, holds it across bursts and locks, and tracks the data-phase owner.
module ahb_output_arbiter
  import ahb_matrix_pkg::*;
#(
  parameter int ARB_SCHEME = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_in0,
  input  logic              req_in1,
  input  logic              req_in2,
  input  logic [1:0]        trans_op,
  input  logic              lock_op,
  input  logic              HREADYM,
  output logic [PORT_W-1:0] addr_in_port,
  output logic              no_port,
  output logic              active_op0,
  output logic              active_op1,
  output logic              active_op2,
  output logic [PORT_W-1:0] data_in_port,
  output logic              data_valid
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [PORT_W-1:0] last_owner;
  logic [PORT_W-1:0] last_nxt;
  logic [PORT_W-1:0] addr_nxt;
  logic [PORT_W-1:0] start;
  logic [PORT_W-1:0] winner;
  logic              no_port_nxt;
  logic              any_req;
  logic              burst;
  logic              release_ok;
  logic              keep;
  logic [2:0]        active_q;

  assign start = (ARB_SCHEME != 0) ? next_port(last_owner) : '0;

  ahb_rr_pick u_pick (
    .req     ({req_in2, req_in1, req_in0}),
    .start   (start),
    .winner  (winner),
    .any_req (any_req)
  );

  // The owner keeps the bus mid-burst and for as long as it asserts lock;
  // a lock is released only at a transfer boundary (IDLE or NONSEQ).
  always_comb begin
    burst       = (trans_op == HTRANS_SEQ) || (trans_op == HTRANS_BUSY);
    release_ok  = (trans_op == HTRANS_IDLE) || (trans_op == HTRANS_NONSEQ);
    keep        = (state == ST_LOCKED) ? (lock_op || !release_ok)
                                       : ((state != ST_IDLE) && (burst || lock_op));
    state_nxt   = state;
    addr_nxt    = addr_in_port;
    no_port_nxt = no_port;
    last_nxt    = last_owner;
    if (keep) begin
      state_nxt = lock_op ? ST_LOCKED : ST_GRANTED;
    end else if (any_req) begin
      state_nxt   = ST_GRANTED;
      addr_nxt    = winner;
      no_port_nxt = 1'b0;
      last_nxt    = winner;
    end else begin
      state_nxt   = ST_IDLE;
      no_port_nxt = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state        <= ST_IDLE;
      last_owner   <= 2'd2;
      addr_in_port <= '0;
      no_port      <= 1'b1;
      active_q     <= 3'b000;
      data_in_port <= '0;
      data_valid   <= 1'b0;
    end else if (HREADYM) begin
      state        <= state_nxt;
      last_owner   <= last_nxt;
      addr_in_port <= addr_nxt;
      no_port      <= no_port_nxt;
      active_q     <= no_port_nxt ? 3'b000 : (3'b001 << addr_nxt);
      data_in_port <= addr_in_port;
      data_valid   <= !no_port && ((trans_op == HTRANS_NONSEQ) || (trans_op == HTRANS_SEQ));
    end
  end

  assign active_op0 = active_q[0];
  assign active_op1 = active_q[1];
  assign active_op2 = active_q[2];

endmodule

// File: tb/tb_ahb_output_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority arbiters share stimulus and
// are compared each cycle against a queue-fed behavioural model.
module tb_ahb_output_arbiter;
  import ahb_matrix_pkg::*;

  logic       HCLK, HRESET;
  logic       req_in0, req_in1, req_in2, lock_op, HREADYM;
  logic [1:0] trans_op;
  logic [1:0] rr_addr, fp_addr, rr_dport, fp_dport;
  logic       rr_no, fp_no, rr_dv, fp_dv;
  logic       rr_a0, rr_a1, rr_a2, fp_a0, fp_a1, fp_a2;

  typedef struct packed {
    logic [1:0] addr;
    logic       no;
    logic [2:0] act;
    logic [1:0] dport;
    logic       dv;
  } out_t;

  out_t exp_rr[$];
  out_t exp_fp[$];
  int   m_owner[2];
  int   m_last[2];
  int   m_addr[2];
  int   m_dport[2];
  bit   m_dv[2];
  int   checks   = 0;
  int   failures = 0;

  ahb_output_arbiter #(.ARB_SCHEME(1)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .req_in0(req_in0), .req_in1(req_in1), .req_in2(req_in2),
    .trans_op(trans_op), .lock_op(lock_op), .HREADYM(HREADYM),
    .addr_in_port(rr_addr), .no_port(rr_no), .active_op0(rr_a0), .active_op1(rr_a1),
    .active_op2(rr_a2), .data_in_port(rr_dport), .data_valid(rr_dv)
  );

  ahb_output_arbiter #(.ARB_SCHEME(0)) u_fp (
    .HCLK(HCLK), .HRESET(HRESET), .req_in0(req_in0), .req_in1(req_in1), .req_in2(req_in2),
    .trans_op(trans_op), .lock_op(lock_op), .HREADYM(HREADYM),
    .addr_in_port(fp_addr), .no_port(fp_no), .active_op0(fp_a0), .active_op1(fp_a1),
    .active_op2(fp_a2), .data_in_port(fp_dport), .data_valid(fp_dv)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare(input string tag, input out_t got, input out_t exp);
    check_output({tag, "_addr_in_port"}, got.addr, exp.addr);
    check_output({tag, "_no_port"}, got.no, exp.no);
    check_output({tag, "_active_op"}, got.act, exp.act);
    check_output({tag, "_data_in_port"}, got.dport, exp.dport);
    check_output({tag, "_data_valid"}, got.dv, exp.dv);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_owner[s] = -1;
      m_last[s]  = 2;
      m_addr[s]  = 0;
      m_dport[s] = 0;
      m_dv[s]    = 1'b0;
    end
  endtask

  // One accepted transfer: owner keeps the bus mid-burst or while locked,
  // otherwise the requesters are searched in priority order.
  task automatic model_step(input int s, input bit rr);
    bit reqv[3];
    int pick, old_owner, old_addr, idx;
    bit cont, xfer;
    if (HREADYM) begin
      reqv[0]   = req_in0;
      reqv[1]   = req_in1;
      reqv[2]   = req_in2;
      old_owner = m_owner[s];
      old_addr  = m_addr[s];
      cont      = (trans_op == 2'b11) || (trans_op == 2'b01);
      xfer      = (trans_op == 2'b10) || (trans_op == 2'b11);
      if (!(old_owner >= 0 && (cont || lock_op))) begin
        pick = -1;
        for (int k = 0; k < 3; k++) begin
          idx = rr ? (m_last[s] + 1 + k) % 3 : k;
          if (pick < 0 && reqv[idx]) pick = idx;
        end
        if (pick >= 0) begin
          m_owner[s] = pick;
          m_last[s]  = pick;
          m_addr[s]  = pick;
        end else begin
          m_owner[s] = -1;
        end
      end
      m_dport[s] = old_addr;
      m_dv[s]    = (old_owner >= 0) && xfer;
    end
  endtask

  function automatic out_t model_out(input int s);
    out_t o;
    o.addr  = 2'(m_addr[s]);
    o.no    = (m_owner[s] < 0);
    o.act   = (m_owner[s] < 0) ? 3'b000 : 3'(1 << m_owner[s]);
    o.dport = 2'(m_dport[s]);
    o.dv    = m_dv[s];
    return o;
  endfunction

  task automatic apply_stimulus(input bit r0, input bit r1, input bit r2,
                                input logic [1:0] t, input bit lk, input bit rdy);
    @(negedge HCLK);
    req_in0  = r0;
    req_in1  = r1;
    req_in2  = r2;
    trans_op = t;
    lock_op  = lk;
    HREADYM  = rdy;
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    exp_rr.push_back(model_out(0));
    exp_fp.push_back(model_out(1));
  endtask

  task automatic quiet_inputs();
    req_in0 = 0; req_in1 = 0; req_in2 = 0;
    trans_op = HTRANS_IDLE; lock_op = 0; HREADYM = 0;
  endtask

  task automatic check_reset(input string tag);
    out_t rst;
    rst = '{addr: 2'd0, no: 1'b1, act: 3'b000, dport: 2'd0, dv: 1'b0};
    compare({tag, "_rr"}, {rr_addr, rr_no, {rr_a2, rr_a1, rr_a0}, rr_dport, rr_dv}, rst);
    compare({tag, "_fp"}, {fp_addr, fp_no, {fp_a2, fp_a1, fp_a0}, fp_dport, fp_dv}, rst);
  endtask

  // Monitor: pops one expectation per DUT for every edge that had stimulus.
  initial begin
    forever begin
      @(posedge HCLK);
      #1;
      if (exp_rr.size() > 0)
        compare("rr", {rr_addr, rr_no, {rr_a2, rr_a1, rr_a0}, rr_dport, rr_dv}, exp_rr.pop_front());
      if (exp_fp.size() > 0)
        compare("fp", {fp_addr, fp_no, {fp_a2, fp_a1, fp_a0}, fp_dport, fp_dv}, exp_fp.pop_front());
    end
  end

  initial begin
    logic [31:0] r;
    HRESET = 1'b1;
    quiet_inputs();
    model_reset();
    @(posedge HCLK);
    #1;
    check_reset("por");
    @(negedge HCLK);
    HRESET = 1'b0;

    apply_stimulus(0, 1, 0, HTRANS_IDLE, 0, 1);
    apply_stimulus(0, 1, 0, HTRANS_NONSEQ, 0, 1);
    apply_stimulus(0, 0, 0, HTRANS_IDLE, 0, 1);
    apply_stimulus(0, 0, 0, HTRANS_IDLE, 0, 1);

    for (int i = 0; i < 7; i++) apply_stimulus(1, 1, 1, HTRANS_NONSEQ, 0, 1);

    apply_stimulus(1, 0, 0, HTRANS_IDLE, 0, 1);
    apply_stimulus(1, 0, 1, HTRANS_NONSEQ, 0, 1);
    apply_stimulus(1, 0, 1, HTRANS_SEQ, 0, 1);
    apply_stimulus(1, 0, 1, HTRANS_SEQ, 0, 1);
    apply_stimulus(1, 0, 1, HTRANS_SEQ, 0, 1);
    apply_stimulus(0, 0, 1, HTRANS_IDLE, 0, 1);
    apply_stimulus(0, 0, 0, HTRANS_NONSEQ, 0, 1);

    apply_stimulus(0, 1, 0, HTRANS_IDLE, 0, 1);
    apply_stimulus(1, 1, 0, HTRANS_NONSEQ, 1, 1);
    apply_stimulus(1, 0, 0, HTRANS_NONSEQ, 1, 1);
    apply_stimulus(1, 1, 0, HTRANS_NONSEQ, 1, 1);
    apply_stimulus(1, 0, 0, HTRANS_NONSEQ, 0, 1);
    apply_stimulus(1, 0, 0, HTRANS_IDLE, 0, 1);

    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 1, HTRANS_NONSEQ, 0, 0);
    apply_stimulus(1, 0, 1, HTRANS_NONSEQ, 0, 1);
    apply_stimulus(1, 0, 1, HTRANS_NONSEQ, 0, 1);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      apply_stimulus(r[0], r[1], r[2], r[4:3], (r[7:5] == 3'd0), (r[9:8] != 2'd0));
    end

    apply_stimulus(1, 0, 1, HTRANS_NONSEQ, 0, 1);
    apply_stimulus(1, 0, 1, HTRANS_SEQ, 0, 1);
    apply_stimulus(1, 0, 1, HTRANS_SEQ, 1, 1);
    @(posedge HCLK);
    #2;
    HRESET = 1'b1;
    quiet_inputs();
    model_reset();
    #1;
    check_reset("async_rst");
    @(negedge HCLK);
    HRESET = 1'b0;
    apply_stimulus(1, 0, 0, HTRANS_IDLE, 0, 1);
    apply_stimulus(1, 0, 0, HTRANS_NONSEQ, 0, 1);
    apply_stimulus(0, 0, 0, HTRANS_IDLE, 0, 1);

    @(posedge HCLK);
    #2;
    check_output("queue_drained", exp_rr.size() + exp_fp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
